// File: rtl/mem_burst_master.sv
// mem_burst_master
//   Burst master for a single-port synchronous RAM (1-cycle read latency).
//   A command (write or read, start address, length-1) is accepted in IDLE.
//   Write bursts stream Wd_* beats straight into the RAM. Read bursts issue
//   RAM reads into a 2-entry return FIFO that feeds the Rd_* stream with
//   full back-pressure support.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   Cmd_Valid/Ready/Wr/Addr/Len   command handshake (burst = Cmd_Len+1 beats)
//   Wd_Valid/Ready/Data           write-data stream
//   Rd_Valid/Ready/Data/Last      read-data stream, Last on the final beat
//   Mem_W_En/Addr/D_Out/D_In      RAM interface
//   Busy                          high whenever not IDLE
//   Done                          one-cycle pulse after a burst completes
module mem_burst_master #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Cmd_Valid,
   output logic              Cmd_Ready,
   input  logic              Cmd_Wr,
   input  logic [ADDR_W-1:0] Cmd_Addr,
   input  logic [LEN_W-1:0]  Cmd_Len,
   input  logic              Wd_Valid,
   output logic              Wd_Ready,
   input  logic [DATA_W-1:0] Wd_Data,
   output logic              Rd_Valid,
   input  logic              Rd_Ready,
   output logic [DATA_W-1:0] Rd_Data,
   output logic              Rd_Last,
   output logic              Mem_W_En,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_D_Out,
   input  logic [DATA_W-1:0] Mem_D_In,
   output logic              Busy,
   output logic              Done
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    beats_q, beats_d;   // issues/writes remaining minus one
   logic [LEN_W-1:0]    pops_q, pops_d;     // read beats to deliver minus one
   logic                done_q, done_d;
   logic                inflight_q, inflight_d;

   logic [DATA_W-1:0]   fifo_q [2];
   logic                wr_ptr_q, rd_ptr_q;
   logic [1:0]          count_q, count_d;

   logic                push, pop, issue;

   assign Cmd_Ready = (state_q == IDLE);
   assign Wd_Ready  = (state_q == WRITE);
   assign Busy      = (state_q != IDLE);
   assign Done      = done_q;
   assign Mem_W_En  = (state_q == WRITE) && Wd_Valid;
   assign Mem_Addr  = addr_q;
   assign Mem_D_Out = (state_q == WRITE) ? Wd_Data : '0;

   assign Rd_Valid  = (count_q != 2'd0);
   assign Rd_Data   = fifo_q[rd_ptr_q];
   assign Rd_Last   = Rd_Valid && (pops_q == '0);

   assign push      = inflight_q;
   assign pop       = Rd_Valid && Rd_Ready;
   // Issue only if the FIFO can still absorb this read after the beat in
   // flight lands; a pop on the same edge frees one slot.
   assign issue     = (state_q == READ) &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      beats_d    = beats_q;
      pops_d     = pops_q;
      done_d     = 1'b0;
      inflight_d = issue;
      count_d    = count_q + {1'b0, push} - {1'b0, pop};

      if (pop && (pops_q != '0)) begin
         pops_d = pops_q - LEN_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (Cmd_Valid) begin
               addr_d  = Cmd_Addr;
               beats_d = Cmd_Len;
               pops_d  = Cmd_Len;
               state_d = Cmd_Wr ? WRITE : READ;
            end
         end
         WRITE: begin
            if (Wd_Valid) begin
               addr_d = addr_q + ADDR_W'(1);
               if (beats_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  beats_d = beats_q - LEN_W'(1);
               end
            end
         end
         READ: begin
            if (issue) begin
               addr_d = addr_q + ADDR_W'(1);
               if (beats_q == '0) begin
                  state_d = DRAIN;
               end else begin
                  beats_d = beats_q - LEN_W'(1);
               end
            end
         end
         DRAIN: begin
            if (pop && (pops_q == '0)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         beats_q    <= '0;
         pops_q     <= '0;
         done_q     <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         beats_q    <= beats_d;
         pops_q     <= pops_d;
         done_q     <= done_d;
         inflight_q <= inflight_d;
      end
   end

   // Return FIFO: RAM output is captured only on the edge after an issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= Mem_D_In;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master
//   Directed bench for mem_burst_master with a behavioural single-port
//   synchronous RAM. Monitors log RAM writes, delivered read beats, command
//   accepts and Done pulses by cycle number; expected values are fixed
//   constants derived by hand from the burst parameters.
module tb_mem_burst_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Cmd_Valid, Cmd_Ready, Cmd_Wr;
   logic [12:0] Cmd_Addr;
   logic [7:0]  Cmd_Len;
   logic        Wd_Valid, Wd_Ready;
   logic [31:0] Wd_Data;
   logic        Rd_Valid, Rd_Ready, Rd_Last;
   logic [31:0] Rd_Data;
   logic        Mem_W_En;
   logic [12:0] Mem_Addr;
   logic [31:0] Mem_D_Out, Mem_D_In;
   logic        Busy, Done;

   mem_burst_master #(.ADDR_W(13), .DATA_W(32), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Wr(Cmd_Wr),
      .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
      .Wd_Valid(Wd_Valid), .Wd_Ready(Wd_Ready), .Wd_Data(Wd_Data),
      .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
      .Mem_W_En(Mem_W_En), .Mem_Addr(Mem_Addr), .Mem_D_Out(Mem_D_Out), .Mem_D_In(Mem_D_In),
      .Busy(Busy), .Done(Done)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: write when enabled, otherwise register the addressed word.
   logic [31:0] ram [0:8191];
   logic [31:0] ram_q = '0;
   assign Mem_D_In = ram_q;
   always @(posedge clk) begin
      if (Mem_W_En) ram[Mem_Addr] <= Mem_D_Out;
      else          ram_q <= ram[Mem_Addr];
   end

   // Event logs
   int          cyc = 0;
   int          acc_cyc = 0;
   int          done_cnt = 0;
   logic [12:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   logic [31:0] rd_q[$];
   logic        rl_q[$];
   int          rc_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (Cmd_Valid && Cmd_Ready) acc_cyc <= cyc;
      if (Mem_W_En) begin
         wa_q.push_back(Mem_Addr); wd_q.push_back(Mem_D_Out); wc_q.push_back(cyc);
      end
      if (Rd_Valid && Rd_Ready) begin
         rd_q.push_back(Rd_Data); rl_q.push_back(Rd_Last); rc_q.push_back(cyc);
      end
      if (Done) done_cnt <= done_cnt + 1;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Called one time unit after a rising edge; returns one unit after the accept edge.
   task automatic issue_cmd(input logic wr, input logic [12:0] addr, input logic [7:0] len);
      check("cmd_ready_before_cmd", Cmd_Ready, 1);
      Cmd_Valid = 1'b1; Cmd_Wr = wr; Cmd_Addr = addr; Cmd_Len = len;
      step();
      Cmd_Valid = 1'b0;
   endtask

   // Wd_Valid follows vpat[0..npat-1], then stays 1; data increments per accepted beat.
   task automatic write_burst(input logic [12:0] addr, input logic [7:0] len,
                              input logic [15:0] vpat, input int npat,
                              input logic [31:0] base, output int start, output int acc);
      int sent = 0;
      int d0;
      logic ok;
      start = wa_q.size();
      d0    = done_cnt;
      issue_cmd(1'b1, addr, len);
      acc = acc_cyc;
      for (int i = 0; i < 300 && sent < int'(len) + 1; i++) begin
         Wd_Valid = (i < npat) ? vpat[i] : 1'b1;
         Wd_Data  = base + 32'(sent);
         #3;
         ok = Wd_Valid && Wd_Ready;
         step();
         if (ok) sent++;
      end
      Wd_Valid = 1'b0;
      step(); step();
      check("wr_beats_accepted", sent, int'(len) + 1);
      check("wr_log_count", wa_q.size() - start, int'(len) + 1);
      check("wr_done_pulses", done_cnt - d0, 1);
      check("wr_cmd_ready_back", Cmd_Ready, 1);
   endtask

   task automatic wait_reads(input int start, input int n);
      for (int k = 0; k < 200; k++) begin
         if (rd_q.size() - start >= n) break;
         step();
      end
      check("rd_beats_delivered", rd_q.size() - start, n);
   endtask

   task automatic finish_read(input int start, input int n, input int d0);
      Rd_Ready = 1'b0;
      step(); step(); step();
      check("rd_no_extra_beats", rd_q.size() - start, n);
      check("rd_done_pulses", done_cnt - d0, 1);
      check("rd_idle_after", Busy, 0);
   endtask

   task automatic read_burst(input logic [12:0] addr, input logic [7:0] len,
                             output int start, output int acc);
      int d0;
      start = rd_q.size();
      d0    = done_cnt;
      issue_cmd(1'b0, addr, len);
      acc = acc_cyc;
      Rd_Ready = 1'b1;
      wait_reads(start, int'(len) + 1);
      finish_read(start, int'(len) + 1, d0);
   endtask

   task automatic verify_reads(input int start, input logic [31:0] base,
                               input int n, input int first_cyc, input bit chk_cyc);
      for (int k = 0; k < n && start + k < rd_q.size(); k++) begin
         check($sformatf("rd_data[%0d]", k), rd_q[start + k], base + 32'(k));
         check($sformatf("rd_last[%0d]", k), rl_q[start + k], (k == n - 1));
         if (chk_cyc) check($sformatf("rd_cycle[%0d]", k), rc_q[start + k], first_cyc + k);
      end
   endtask

   task automatic verify_writes(input int start, input logic [12:0] addr,
                                input logic [31:0] base, input int n);
      logic [12:0] ea;
      for (int k = 0; k < n && start + k < wa_q.size(); k++) begin
         ea = addr + 13'(k);
         check($sformatf("wr_addr[%0d]", k), wa_q[start + k], ea);
         check($sformatf("wr_data[%0d]", k), wd_q[start + k], base + 32'(k));
      end
   endtask

   int ws, wacc, rs, racc, d0;

   initial begin
      rst_n = 1'b0; Cmd_Valid = 1'b0; Cmd_Wr = 1'b0; Cmd_Addr = '0; Cmd_Len = '0;
      Wd_Valid = 1'b0; Wd_Data = '0; Rd_Ready = 1'b0;
      step(); step();

      // Reset values
      check("rst_cmd_ready", Cmd_Ready, 1);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_rd_valid", Rd_Valid, 0);
      check("rst_rd_last", Rd_Last, 0);
      check("rst_wd_ready", Wd_Ready, 0);
      check("rst_mem_w_en", Mem_W_En, 0);
      check("rst_mem_addr", Mem_Addr, 0);
      rst_n = 1'b1;
      step();

      // Write 0x0010 len 3, data A0..A3 on consecutive cycles
      write_burst(13'h0010, 8'd3, 16'hFFFF, 0, 32'hA0, ws, wacc);
      verify_writes(ws, 13'h0010, 32'hA0, 4);
      for (int k = 0; k < 4 && ws + k < wc_q.size(); k++)
         check($sformatf("wr_cycle[%0d]", k), wc_q[ws + k], wacc + 1 + k);

      // Read it back: first beat popped 3 edges after accept, then one per clock
      read_burst(13'h0010, 8'd3, rs, racc);
      verify_reads(rs, 32'hA0, 4, racc + 3, 1'b1);

      // Stalled read of 8 words
      write_burst(13'h0020, 8'd7, 16'hFFFF, 0, 32'hB0, ws, wacc);
      verify_writes(ws, 13'h0020, 32'hB0, 8);
      rs = rd_q.size();
      d0 = done_cnt;
      issue_cmd(1'b0, 13'h0020, 8'd7);
      Rd_Ready = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check("stall_two_issues_addr", Mem_Addr, 13'h0022);
      check("stall_rd_valid", Rd_Valid, 1);
      check("stall_rd_data_head", Rd_Data, 32'hB0);
      check("stall_busy", Busy, 1);
      step();
      check("stall_rd_data_stable", Rd_Data, 32'hB0);
      Rd_Ready = 1'b1;
      wait_reads(rs, 8);
      finish_read(rs, 8, d0);
      verify_reads(rs, 32'hB0, 8, 0, 1'b0);

      // Address wrap
      write_burst(13'h1FFE, 8'd3, 16'hFFFF, 0, 32'hC0, ws, wacc);
      verify_writes(ws, 13'h1FFE, 32'hC0, 4);
      read_burst(13'h1FFE, 8'd3, rs, racc);
      verify_reads(rs, 32'hC0, 4, racc + 3, 1'b1);

      // Gappy Wd_Valid 1,0,0,1,1,0,1
      write_burst(13'h0040, 8'd3, 16'b1011001, 7, 32'hD0, ws, wacc);
      verify_writes(ws, 13'h0040, 32'hD0, 4);
      if (ws + 3 < wc_q.size()) begin
         check("gap_wr_cycle0", wc_q[ws + 0], wacc + 1);
         check("gap_wr_cycle1", wc_q[ws + 1], wacc + 4);
         check("gap_wr_cycle2", wc_q[ws + 2], wacc + 5);
         check("gap_wr_cycle3", wc_q[ws + 3], wacc + 7);
      end

      // Single-beat read
      read_burst(13'h0041, 8'd0, rs, racc);
      verify_reads(rs, 32'hD1, 1, racc + 3, 1'b1);

      // Reset during the third beat of a read burst
      rs = rd_q.size();
      issue_cmd(1'b0, 13'h0020, 8'd7);
      Rd_Ready = 1'b1;
      for (int k = 0; k < 50 && rd_q.size() - rs < 2; k++) step();
      check("mid_rd_third_beat", Rd_Data, 32'hB2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", Busy, 0);
      check("arst_cmd_ready", Cmd_Ready, 1);
      check("arst_rd_valid", Rd_Valid, 0);
      check("arst_rd_last", Rd_Last, 0);
      check("arst_mem_addr", Mem_Addr, 0);
      check("arst_mem_w_en", Mem_W_En, 0);
      check("arst_wd_ready", Wd_Ready, 0);
      check("arst_done", Done, 0);
      step(); step();
      check("arst_no_more_reads", rd_q.size() - rs, 2);
      rst_n = 1'b1;
      step();
      read_burst(13'h0010, 8'd3, rs, racc);
      verify_reads(rs, 32'hA0, 4, racc + 3, 1'b1);

      // Reset during a write burst: no RAM write once reset is asserted
      ws = wa_q.size();
      issue_cmd(1'b1, 13'h0060, 8'd3);
      Wd_Valid = 1'b1; Wd_Data = 32'hE0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("wrst_mem_w_en", Mem_W_En, 0);
      step(); step();
      check("wrst_write_count", wa_q.size() - ws, 1);
      Wd_Valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("wrst_idle_after", Cmd_Ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
